// File: rtl/uart_pkg.sv
// Shared UART receive-path constants, frame layout and FSM state type.
// Imported by the RX deserializer and its helpers.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned FRAME_BITS = 11;

  // Bit positions inside a captured frame
  localparam int unsigned START_IDX  = 0;
  localparam int unsigned DATA_LSB   = 1;
  localparam int unsigned DATA_MSB   = 8;
  localparam int unsigned PARITY_IDX = 9;
  localparam int unsigned STOP_IDX   = 10;

  localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BIT  = 4'(STOP_IDX);

  typedef logic [FRAME_BITS-1:0] frame_t;

  localparam frame_t FRAME_IDLE = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Resets to 1 so an idle-high serial line does not look like a start bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/sipo.sv
// UART RX deserializer: captures start, 8 data bits, parity and stop from the
// 16x oversampled line and presents the raw 11-bit frame with a level flag.
module sipo
  import uart_pkg::*;
(
  input  logic                  baud_clk,
  input  logic                  reset_n,
  input  logic                  data_tx,
  output logic                  recieved_flag,
  output logic [FRAME_BITS-1:0] data_parll
);

  logic      rx_s;
  rx_state_e state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [3:0] bit_q, bit_d;
  frame_t    shreg_q, shreg_d;
  frame_t    parll_q, parll_d;
  logic      flag_q, flag_d;

  sync_2ff u_sync (
    .clk   (baud_clk),
    .rst_n (reset_n),
    .d     (data_tx),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    parll_d = parll_q;
    flag_d  = flag_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          tick_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick_q == TICK_MID) begin
          // A line that is high again by mid start bit was only a glitch
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            shreg_d = {rx_s, shreg_q[FRAME_BITS-1:1]};
            bit_d   = 4'd1;
            flag_d  = 1'b0;
            tick_d  = '0;
            state_d = DATA;
          end
        end else begin
          tick_d = tick_q + 4'd1;
        end
      end
      DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shreg_d = {rx_s, shreg_q[FRAME_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == LAST_BIT) begin
            state_d = DONE;
          end
        end else begin
          tick_d = tick_q + 4'd1;
        end
      end
      DONE: begin
        parll_d = shreg_q;
        flag_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= FRAME_IDLE;
      parll_q <= FRAME_IDLE;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      parll_q <= parll_d;
      flag_q  <= flag_d;
    end
  end

  assign recieved_flag = flag_q;
  assign data_parll    = parll_q;

endmodule

// File: tb/tb_sipo.sv
// Bench for sipo: table-driven frames, glitch and mid-frame reset sequences,
// then random frames checked against a field-level frame model.
`timescale 1ns/100ps
module tb_sipo;

  localparam realtime HALF = 3255.2;

  logic        baud_clk = 1'b0;
  logic        reset_n;
  logic        data_tx = 1'b1;
  logic        recieved_flag;
  logic [10:0] data_parll;

  int n_checks = 0;
  int n_pass   = 0;
  logic [10:0] last_frame;

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic        stop;
    int unsigned gap;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[5];

  sipo dut (
    .baud_clk      (baud_clk),
    .reset_n       (reset_n),
    .data_tx       (data_tx),
    .recieved_flag (recieved_flag),
    .data_parll    (data_parll)
  );

  always #HALF baud_clk = ~baud_clk;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val >= lo && val <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic idle(input int n);
    data_tx = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Model of one frame on the wire: start 0, data LSB first, parity, stop
  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1+k] = d[k];
    f[9]  = p;
    f[10] = s;
    return f;
  endfunction

  task automatic send_frame(input string name, input logic [7:0] d, input logic p,
                            input logic s, input int unsigned gap, input logic [10:0] exp);
    logic [10:0] bits;
    int rise_at;
    int n;
    bits    = model_frame(d, p, s);
    rise_at = -1;
    n       = 0;
    for (int b = 0; b < 11; b++) begin
      for (int t = 0; t < 16; t++) begin
        data_tx = bits[b];
        tick();
        n++;
        if (b == 0 && t == 13) begin
          check_val({name, " flag cleared at start"}, 32'(recieved_flag), 32'd0);
          check_val({name, " parll held"}, 32'(data_parll), 32'(last_frame));
        end
        if (rise_at < 0 && b > 0 && recieved_flag) rise_at = n;
      end
    end
    data_tx = 1'b1;
    for (int i = 0; i < int'(gap); i++) begin
      tick();
      n++;
      if (rise_at < 0 && recieved_flag) rise_at = n;
    end
    for (int i = 0; i < 40 && rise_at < 0; i++) begin
      tick();
      n++;
      if (recieved_flag) rise_at = n;
    end
    check_range({name, " flag rise tick"}, rise_at, 166, 176);
    check_val({name, " data_parll"}, 32'(data_parll), 32'(exp));
    last_frame = exp;
  endtask

  initial begin
    #300_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    logic        rp;
    logic        rs;
    int unsigned rg;

    vecs[0] = '{8'h55, 1'b1, 1'b1, 0,  11'b11010101010};
    vecs[1] = '{8'hA3, 1'b0, 1'b1, 20, 11'b10101000110};
    vecs[2] = '{8'h0F, 1'b1, 1'b0, 24, 11'b01000011110};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 0,  11'b10111111110};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 10, 11'b10000000000};

    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #100 reset_n = 1'b1;
    #1;
    check_val("reset flag", 32'(recieved_flag), 32'd0);
    check_val("reset parll", 32'(data_parll), 32'h7FF);
    idle(32);
    check_val("idle flag", 32'(recieved_flag), 32'd0);
    check_val("idle parll", 32'(data_parll), 32'h7FF);
    last_frame = 11'h7FF;

    for (int i = 0; i < 5; i++) begin
      send_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par, vecs[i].stop,
                 vecs[i].gap, vecs[i].exp);
    end

    // Short low pulses must not start a frame
    data_tx = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    idle(40);
    check_val("glitch4 flag", 32'(recieved_flag), 32'd1);
    check_val("glitch4 parll", 32'(data_parll), 32'(last_frame));
    data_tx = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    idle(40);
    check_val("glitch6 flag", 32'(recieved_flag), 32'd1);
    check_val("glitch6 parll", 32'(data_parll), 32'(last_frame));

    // Reset during data bit 4 discards the partial frame
    rd = 8'h5A;
    data_tx = 1'b0;
    for (int t = 0; t < 16; t++) tick();
    for (int b = 0; b < 3; b++) begin
      data_tx = rd[b];
      for (int t = 0; t < 16; t++) tick();
    end
    data_tx = rd[3];
    for (int t = 0; t < 8; t++) tick();
    #200 reset_n = 1'b0;
    #1;
    check_val("midreset flag", 32'(recieved_flag), 32'd0);
    check_val("midreset parll", 32'(data_parll), 32'h7FF);
    data_tx = 1'b1;
    #50 reset_n = 1'b1;
    idle(20);
    check_val("postreset flag", 32'(recieved_flag), 32'd0);
    check_val("postreset parll", 32'(data_parll), 32'h7FF);
    last_frame = 11'h7FF;
    send_frame("after reset", 8'h3C, 1'b1, 1'b1, 10, 11'b11001111000);

    for (int i = 0; i < 12; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      rg = rs ? $urandom_range(0, 30) : $urandom_range(16, 40);
      send_frame($sformatf("rand%0d", i), rd, rp, rs, rg, model_frame(rd, rp, rs));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
